// File: rtl/dmem_pkg.sv
// Shared address map, timer register layout and region decode for dmem_responder.
// The timer block is only built when DMEM_RESPONDER_TIMER_EN is defined.
package dmem_pkg;

    localparam logic [31:0] TIMER_BASE_DEFAULT = 32'hFFFF_0000;

    localparam logic [3:0] TCTRL_OFF  = 4'h0;
    localparam logic [3:0] TLOAD_OFF  = 4'h4;
    localparam logic [3:0] TCOUNT_OFF = 4'h8;
    localparam logic [3:0] TSTAT_OFF  = 4'hC;

    localparam int TCTRL_EN     = 0;
    localparam int TCTRL_IE     = 1;
    localparam int TCTRL_AUTO   = 2;
    localparam int TSTAT_PEND   = 0;
    localparam int TSTAT_BUSERR = 1;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_TIMER,
        REGION_UNMAPPED
    } region_t;

    // Byte-address decode; the low two address bits never affect the region.
    function automatic region_t decodeRegion(
        input logic [31:0] addr,
        input logic [31:0] timerBase,
        input int unsigned ramBytesLog2,
        input logic        timerPresent
    );
        if ((addr >> ramBytesLog2) == 32'h0)
            return REGION_RAM;
        else if (timerPresent && ((addr & ~32'hF) == (timerBase & ~32'hF)))
            return REGION_TIMER;
        else
            return REGION_UNMAPPED;
    endfunction

endpackage

// File: rtl/dmem_timer.sv
// Timer register file (TCTRL/TLOAD/TCOUNT/TSTAT), down-counter and pending-interrupt logic.
// Instantiated by dmem_responder only when DMEM_RESPONDER_TIMER_EN is defined.
module dmem_timer
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wrEn,
    input  logic [1:0]  regIdx,
    input  logic [31:0] writedata,
    input  logic        busErrSet,
    output logic [31:0] rdata,
    output logic        nIRQ
);

    logic        en;
    logic        ie;
    logic        autoReload;
    logic        pend;
    logic        busErr;
    logic [31:0] tload;
    logic [31:0] tcount;

    logic ctrlWr;
    logic loadWr;
    logic statWr;
    logic expire;

    assign ctrlWr = wrEn && (regIdx == TCTRL_OFF[3:2]);
    assign loadWr = wrEn && (regIdx == TLOAD_OFF[3:2]);
    assign statWr = wrEn && (regIdx == TSTAT_OFF[3:2]);

    // An expiry is still recognised when TLOAD is written in the same cycle.
    assign expire = en && (tcount == 32'h0);

    always_ff @(posedge clk) begin
        if (reset) begin
            en         <= 1'b0;
            ie         <= 1'b0;
            autoReload <= 1'b0;
            pend       <= 1'b0;
            busErr     <= 1'b0;
            tload      <= 32'h0;
            tcount     <= 32'h0;
        end else begin
            if (ctrlWr) begin
                en         <= writedata[TCTRL_EN];
                ie         <= writedata[TCTRL_IE];
                autoReload <= writedata[TCTRL_AUTO];
            end else if (expire && !autoReload) begin
                en <= 1'b0;
            end

            if (loadWr) begin
                tload  <= writedata;
                tcount <= writedata;
            end else if (en) begin
                if (tcount != 32'h0)
                    tcount <= tcount - 32'd1;
                else if (autoReload)
                    tcount <= tload;
            end

            // Set beats write-1-to-clear when both land on the same edge.
            if (expire)
                pend <= 1'b1;
            else if (statWr && writedata[TSTAT_PEND])
                pend <= 1'b0;

            if (busErrSet)
                busErr <= 1'b1;
            else if (statWr && writedata[TSTAT_BUSERR])
                busErr <= 1'b0;
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (regIdx)
            TCTRL_OFF[3:2]:  rdata = {29'h0, autoReload, ie, en};
            TLOAD_OFF[3:2]:  rdata = tload;
            TCOUNT_OFF[3:2]: rdata = tcount;
            default:         rdata = {30'h0, busErr, pend};
        endcase
    end

    assign nIRQ = ~(pend & ie);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: address decode, byte-enabled RAM and combinational read mux.
// Define DMEM_RESPONDER_TIMER_EN to map the dmem_timer register block at TIMER_BASE.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] TIMER_BASE  = TIMER_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memaddr,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [3:0]  be,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        nIRQ
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

`ifdef DMEM_RESPONDER_TIMER_EN
    localparam logic TIMER_PRESENT = 1'b1;
`else
    localparam logic TIMER_PRESENT = 1'b0;
`endif

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] wordIdx;
    region_t       region;
    logic          ramWr;
    logic          badWr;
    logic [31:0]   timerRdata;

    assign region  = decodeRegion(memaddr, TIMER_BASE, AW + 2, TIMER_PRESENT);
    assign wordIdx = memaddr[AW+1:2];
    assign ramWr   = memwrite && !reset && (region == REGION_RAM);
    assign badWr   = memwrite && (region == REGION_UNMAPPED);

    // RAM has no reset; the combinational read below sees the pre-edge contents.
    always_ff @(posedge clk) begin
        if (ramWr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[wordIdx][8*b +: 8] <= writedata[8*b +: 8];
            end
        end
    end

`ifdef DMEM_RESPONDER_TIMER_EN
    logic timerWr;

    assign timerWr = memwrite && (region == REGION_TIMER);

    dmem_timer uTimer (
        .clk       (clk),
        .reset     (reset),
        .wrEn      (timerWr),
        .regIdx    (memaddr[3:2]),
        .writedata (writedata),
        .busErrSet (badWr),
        .rdata     (timerRdata),
        .nIRQ      (nIRQ)
    );
`else
    // Without the timer there is no status register, so the bus error flag has no pin.
    logic busErr;
    logic unusedSink;

    always_ff @(posedge clk) begin
        if (reset)
            busErr <= 1'b0;
        else if (badWr)
            busErr <= 1'b1;
    end

    assign unusedSink = busErr;
    assign timerRdata = 32'h0;
    assign nIRQ       = 1'b1;
`endif

    always_comb begin
        readdata = 32'h0;
        if (memread) begin
            case (region)
                REGION_RAM:   readdata = mem[wordIdx];
                REGION_TIMER: readdata = timerRdata;
                default:      readdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: random RAM traffic against an array model,
// plus directed bus-error, reset and (with DMEM_RESPONDER_TIMER_EN) timer scenarios.
module tb_dmem_responder;

    localparam logic [31:0] TBASE = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] memaddr;
    logic        memwrite;
    logic        memread;
    logic [3:0]  be;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        nIRQ;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ramModel [1024];
    logic        expBusErr = 1'b0;

    always #20 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .TIMER_BASE  (TBASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memaddr   (memaddr),
        .memwrite  (memwrite),
        .memread   (memread),
        .be        (be),
        .writedata (writedata),
        .readdata  (readdata),
        .nIRQ      (nIRQ)
    );

    function automatic logic isRam(input logic [31:0] a);
        return a < 32'h1000;
    endfunction

    function automatic logic isTimer(input logic [31:0] a);
`ifdef DMEM_RESPONDER_TIMER_EN
        return a[31:4] == TBASE[31:4];
`else
        return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
    endfunction

    // One write cycle; the model applies the rules of the address map.
    task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] byteEn, input logic [31:0] data);
        memaddr   = addr;
        be        = byteEn;
        writedata = data;
        memwrite  = 1'b1;
        memread   = 1'b0;
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        if (isRam(addr)) begin
            for (int b = 0; b < 4; b++)
                if (byteEn[b]) ramModel[addr[11:2]][8*b +: 8] = data[8*b +: 8];
        end else if (!isTimer(addr)) begin
            expBusErr = 1'b1;
        end else if (addr[3:0] == 4'hC && data[1]) begin
            expBusErr = 1'b0;
        end
    endtask

    task automatic readWord(input logic [31:0] addr, output logic [31:0] data);
        memaddr = addr;
        memread = 1'b1;
        #1;
        data    = readdata;
        memread = 1'b0;
        #1;
    endtask

    task automatic getBusErr(output logic b);
`ifdef DMEM_RESPONDER_TIMER_EN
        logic [31:0] v;
        readWord(TBASE + 32'hC, v);
        b = v[1];
`else
        b = dut.busErr;
`endif
    endtask

    function automatic logic [31:0] idxAddr(input int unsigned i);
        int unsigned w;
        w = (i < 16) ? (16 + i) : (1008 + i - 16);
        return w * 4;
    endfunction

    task automatic test_reset();
        logic b;
        logic [31:0] v;
        reset = 1'b1; memwrite = 1'b0; memread = 1'b0;
        memaddr = 32'h0; be = 4'h0; writedata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        expBusErr = 1'b0;
        checks++;
        if (nIRQ !== 1'b1) begin failures++; $display("[TB] FAIL reset_nirq got=%b exp=1", nIRQ); end
        getBusErr(b);
        checks++;
        if (b !== 1'b0) begin failures++; $display("[TB] FAIL reset_buserr got=%b exp=0", b); end
`ifdef DMEM_RESPONDER_TIMER_EN
        for (int i = 0; i < 4; i++) begin
            readWord(TBASE + 4 * i, v);
            checks++;
            if (v !== 32'h0) begin failures++; $display("[TB] FAIL reset_reg%0d got=%h exp=0", i, v); end
        end
`endif
    endtask

    task automatic test_byte_enable();
        logic [31:0] v;
        applyStimulus(32'h10, 4'b1111, 32'hDEADBEEF);
        applyStimulus(32'h10, 4'b0010, 32'h0000AA00);
        readWord(32'h10, v);
        checks++;
        if (v !== 32'hDEADAAEF) begin failures++; $display("[TB] FAIL byte_enable got=%h exp=deadaaef", v); end
        applyStimulus(32'h10, 4'b0000, 32'h01234567);
        readWord(32'h10, v);
        checks++;
        if (v !== 32'hDEADAAEF) begin failures++; $display("[TB] FAIL be_zero got=%h exp=deadaaef", v); end
    endtask

    task automatic test_read_gating();
        logic [31:0] v;
        logic b;
        memaddr = 32'h10;
        memread = 1'b0;
        #1;
        checks++;
        if (readdata !== 32'h0) begin failures++; $display("[TB] FAIL read_gated got=%h exp=0", readdata); end
        readWord(32'h2000, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("[TB] FAIL unmapped_read got=%h exp=0", v); end
        readWord(32'h1000, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("[TB] FAIL ram_end_read got=%h exp=0", v); end
        getBusErr(b);
        checks++;
        if (b !== 1'b0) begin failures++; $display("[TB] FAIL read_no_buserr got=%b exp=0", b); end
    endtask

    task automatic test_timer_unmapped();
`ifndef DMEM_RESPONDER_TIMER_EN
        logic [31:0] v;
        logic b;
        for (int i = 0; i < 4; i++) begin
            readWord(TBASE + 4 * i, v);
            checks++;
            if (v !== 32'h0) begin failures++; $display("[TB] FAIL notimer_read%0d got=%h exp=0", i, v); end
        end
        applyStimulus(TBASE + 32'h4, 4'hF, 32'h5);
        getBusErr(b);
        checks++;
        if (b !== 1'b1) begin failures++; $display("[TB] FAIL notimer_write_buserr got=%b exp=1", b); end
        checks++;
        if (nIRQ !== 1'b1) begin failures++; $display("[TB] FAIL notimer_nirq got=%b exp=1", nIRQ); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        expBusErr = 1'b0;
        getBusErr(b);
        checks++;
        if (b !== 1'b0) begin failures++; $display("[TB] FAIL notimer_reset_buserr got=%b exp=0", b); end
`endif
    endtask

    task automatic test_bus_error();
        logic [31:0] v;
        logic b;
        applyStimulus(32'h0, 4'hF, 32'hA5A5_5A5A);
        applyStimulus(32'h8000_0000, 4'hF, 32'hFFFF_FFFF);
        readWord(32'h0, v);
        checks++;
        if (v !== ramModel[0]) begin failures++; $display("[TB] FAIL buserr_ram_kept got=%h exp=%h", v, ramModel[0]); end
        getBusErr(b);
        checks++;
        if (b !== 1'b1) begin failures++; $display("[TB] FAIL buserr_set got=%b exp=1", b); end
`ifdef DMEM_RESPONDER_TIMER_EN
        applyStimulus(TBASE + 32'hC, 4'h0, 32'h2);
        getBusErr(b);
        checks++;
        if (b !== 1'b0) begin failures++; $display("[TB] FAIL buserr_w1c got=%b exp=0", b); end
`endif
    endtask

    task automatic test_same_cycle();
        memaddr   = 32'h10;
        memread   = 1'b1;
        memwrite  = 1'b1;
        be        = 4'hF;
        writedata = 32'h1234_5678;
        #1;
        checks++;
        if (readdata !== ramModel[4]) begin failures++; $display("[TB] FAIL same_cycle_old got=%h exp=%h", readdata, ramModel[4]); end
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        ramModel[4] = 32'h1234_5678;
        checks++;
        if (readdata !== 32'h1234_5678) begin failures++; $display("[TB] FAIL same_cycle_new got=%h exp=12345678", readdata); end
        memread = 1'b0;
        #1;
    endtask

    task automatic test_random_ram();
        logic [31:0] a, d, v, rr;
        logic [3:0]  b;
        logic        e;
        int unsigned k, op;
        for (int i = 0; i < 32; i++) applyStimulus(idxAddr(i), 4'hF, $urandom());
        for (int n = 0; n < 300; n++) begin
            k  = $urandom_range(0, 31);
            op = $urandom_range(0, 3);
            if (op == 0) begin
                b = 4'($urandom_range(0, 15));
                d = $urandom();
                applyStimulus(idxAddr(k) | 32'($urandom_range(0, 3)), b, d);
            end else if (op == 3) begin
                rr = $urandom();
                if (rr[0]) a = 32'h1000 + (rr & 32'hFFC);
                else       a = {1'b1, rr[30:0]};
                if (a[31:4] == TBASE[31:4]) a[8] = ~a[8];
                if (rr[1]) begin
                    applyStimulus(a, 4'hF, $urandom());
                end else begin
                    readWord(a, v);
                    checks++;
                    if (v !== 32'h0) begin failures++; $display("[TB] FAIL rand_unmapped_read addr=%h got=%h exp=0", a, v); end
                end
            end else begin
                a = idxAddr(k) | 32'($urandom_range(0, 3));
                readWord(a, v);
                checks++;
                if (v !== ramModel[a[11:2]]) begin failures++; $display("[TB] FAIL rand_read addr=%h got=%h exp=%h", a, v, ramModel[a[11:2]]); end
                @(posedge clk);
                #1;
            end
        end
        getBusErr(e);
        checks++;
        if (e !== expBusErr) begin failures++; $display("[TB] FAIL rand_buserr got=%b exp=%b", e, expBusErr); end
    endtask

    task automatic test_timer_period();
`ifdef DMEM_RESPONDER_TIMER_EN
        logic [31:0] v;
        applyStimulus(TBASE + 32'h4, 4'hF, 32'd3);
        applyStimulus(TBASE + 32'h0, 4'hF, 32'h7);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            readWord(TBASE + 32'hC, v);
            checks++;
            if (v[0] !== 1'(k == 4)) begin failures++; $display("[TB] FAIL pend_delay cycle=%0d got=%b exp=%b", k, v[0], k == 4); end
        end
        checks++;
        if (nIRQ !== 1'b0) begin failures++; $display("[TB] FAIL irq_assert got=%b exp=0", nIRQ); end
        applyStimulus(TBASE + 32'hC, 4'hF, 32'h1);
        checks++;
        if (nIRQ !== 1'b1) begin failures++; $display("[TB] FAIL irq_w1c got=%b exp=1", nIRQ); end
        readWord(TBASE + 32'h8, v);
        checks++;
        if (v !== 32'd2) begin failures++; $display("[TB] FAIL auto_reload_count got=%h exp=2", v); end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            readWord(TBASE + 32'hC, v);
            checks++;
            if (v[0] !== 1'(k == 3)) begin failures++; $display("[TB] FAIL auto_period cycle=%0d got=%b exp=%b", k, v[0], k == 3); end
        end
        applyStimulus(TBASE + 32'h0, 4'hF, 32'h0);
        applyStimulus(TBASE + 32'hC, 4'hF, 32'h1);
`endif
    endtask

    task automatic test_oneshot();
`ifdef DMEM_RESPONDER_TIMER_EN
        logic [31:0] v;
        applyStimulus(TBASE + 32'h4, 4'hF, 32'h0);
        applyStimulus(TBASE + 32'h0, 4'hF, 32'h3);
        @(posedge clk);
        #1;
        readWord(TBASE + 32'hC, v);
        checks++;
        if (v[0] !== 1'b1) begin failures++; $display("[TB] FAIL oneshot_pend got=%b exp=1", v[0]); end
        readWord(TBASE + 32'h0, v);
        checks++;
        if (v !== 32'h2) begin failures++; $display("[TB] FAIL oneshot_ctrl got=%h exp=2", v); end
        checks++;
        if (nIRQ !== 1'b0) begin failures++; $display("[TB] FAIL oneshot_irq got=%b exp=0", nIRQ); end
        @(posedge clk);
        #1;
        readWord(TBASE + 32'h8, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("[TB] FAIL oneshot_count got=%h exp=0", v); end
        applyStimulus(TBASE + 32'hC, 4'hF, 32'h1);
`endif
    endtask

    task automatic test_w1c_race();
`ifdef DMEM_RESPONDER_TIMER_EN
        logic [31:0] v;
        applyStimulus(TBASE + 32'h4, 4'hF, 32'd1);
        applyStimulus(TBASE + 32'h0, 4'hF, 32'h1);
        @(posedge clk);
        #1;
        applyStimulus(TBASE + 32'hC, 4'hF, 32'h1);
        readWord(TBASE + 32'hC, v);
        checks++;
        if (v[0] !== 1'b1) begin failures++; $display("[TB] FAIL w1c_race_pend got=%b exp=1", v[0]); end
        applyStimulus(TBASE + 32'hC, 4'hF, 32'h1);
        readWord(TBASE + 32'hC, v);
        checks++;
        if (v[0] !== 1'b0) begin failures++; $display("[TB] FAIL w1c_clear got=%b exp=0", v[0]); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        logic b;
`ifdef DMEM_RESPONDER_TIMER_EN
        applyStimulus(TBASE + 32'h4, 4'hF, 32'd2);
        applyStimulus(TBASE + 32'h0, 4'hF, 32'h7);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (nIRQ !== 1'b0) begin failures++; $display("[TB] FAIL mid_irq got=%b exp=0", nIRQ); end
`endif
        applyStimulus(32'h8000_0000, 4'hF, 32'h0);
        getBusErr(b);
        checks++;
        if (b !== 1'b1) begin failures++; $display("[TB] FAIL mid_buserr got=%b exp=1", b); end
        reset     = 1'b1;
        memaddr   = TBASE + 32'h4;
        writedata = 32'd5;
        be        = 4'hF;
        memwrite  = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        memwrite  = 1'b0;
        expBusErr = 1'b0;
        checks++;
        if (nIRQ !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_irq got=%b exp=1", nIRQ); end
        getBusErr(b);
        checks++;
        if (b !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_buserr got=%b exp=0", b); end
`ifdef DMEM_RESPONDER_TIMER_EN
        for (int i = 0; i < 4; i++) begin
            readWord(TBASE + 4 * i, v);
            checks++;
            if (v !== 32'h0) begin failures++; $display("[TB] FAIL post_reset_reg%0d got=%h exp=0", i, v); end
        end
`endif
        readWord(32'h10, v);
        checks++;
        if (v !== ramModel[4]) begin failures++; $display("[TB] FAIL ram_retained got=%h exp=%h", v, ramModel[4]); end
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_read_gating();
        test_timer_unmapped();
        test_bus_error();
        test_same_cycle();
        test_random_ram();
        test_timer_period();
        test_oneshot();
        test_w1c_race();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, RAM depth in 32-bit words (power of two).
REQ-002 SHALL have parameter TIMER_BASE, default 32'hFFFF_0000, base address of the timer register block.
REQ-003 Clock and reset SHALL be: clk  input  1  single clock, all state on rising edge; reset  input  1  synchronous, active-high.
REQ-004 SHALL have port memaddr  input  32  byte address from the processor.
REQ-005 SHALL have port memwrite  input  1  write strobe, sampled at the rising edge.
REQ-006 SHALL have port memread  input  1  read enable.
REQ-007 SHALL have port be  input  4  byte enables; bit n selects bits [8n+7:8n].
REQ-008 SHALL have port writedata  input  32  write data.
REQ-009 SHALL have port readdata  output  32  read data, valid in the same cycle as the address.
REQ-010 SHALL have port nIRQ  output  1  active-low interrupt to the processor.

Function
REQ-011 The address map SHALL be: RAM at 0 .. DEPTH_WORDS*4-1, with word index memaddr[log2(DEPTH_WORDS)+1:2]; timer registers at TIMER_BASE+0x0/0x4/0x8/0xC; everything else unmapped.
REQ-012 Reads SHALL be combinational: readdata = selected word when memread=1, and 32'h0 when memread=0 or the address is unmapped.
REQ-013 RAM writes SHALL occur at the rising edge when memwrite=1, updating only the bytes with be[n]=1; be=0000 SHALL leave RAM unchanged.
REQ-014 A read of the address being written in the same cycle SHALL return the old data.
REQ-015 Timer writes SHALL ignore be and write the full word.
REQ-016 TCTRL (+0x0) SHALL be read/write: bit0 EN, bit1 IE, bit2 AUTO; other bits read 0.
REQ-017 TLOAD (+0x4) SHALL be read/write; a write SHALL also load TCOUNT with writedata at the same edge.
REQ-018 TCOUNT (+0x8) SHALL be read-only; writes to it SHALL be ignored.
REQ-019 TSTAT (+0xC) SHALL have bit0 PEND and bit1 BUSERR, each write-1-to-clear.
REQ-020 Per cycle with EN=1 and no TLOAD write:
- if TCOUNT != 0: TCOUNT decrements by 1;
- if TCOUNT == 0: PEND sets; if AUTO=1, TCOUNT reloads from TLOAD; if AUTO=0, EN clears and TCOUNT holds 0.
REQ-021 An expiry and a W1C write to PEND in the same cycle SHALL leave PEND=1 (set wins).
REQ-022 A TLOAD write in the same cycle as an expiry SHALL load writedata, and PEND SHALL still set.
REQ-023 A TCTRL write clearing EN SHALL take priority over an AUTO reload of EN.
REQ-024 nIRQ SHALL equal ~(PEND & IE), driven from registers only (no combinational path from the inputs).
REQ-025 A write to an unmapped address SHALL be dropped and SHALL set BUSERR; unmapped reads SHALL NOT set BUSERR.
REQ-026 Loading TLOAD=N with EN=1 and AUTO=1 SHALL give an expiry every N+1 cycles.

Reset
REQ-027 When reset=1 at a rising edge: TCTRL=0, TLOAD=0, TCOUNT=0, PEND=0, BUSERR=0, so nIRQ=1 from the next cycle.
REQ-028 Reset SHALL take priority over any write or timer event in the same cycle.
REQ-029 RAM contents SHALL NOT be reset.
REQ-030 readdata SHALL follow REQ-012 during reset.

Configuration
REQ-031 Macro DMEM_RESPONDER_TIMER_EN SHALL compile the timer in.
REQ-032 Without DMEM_RESPONDER_TIMER_EN:
- timer addresses SHALL behave as unmapped (read 0, writes set BUSERR);
- nIRQ SHALL be tied to 1;
- BUSERR SHALL be held in an internal register observable only by the bench.

Structure
REQ-033 Package dmem_pkg SHALL hold:
- the address-map constants: default TIMER_BASE and the register offsets;
- the TCTRL/TSTAT bit positions;
- a region-select enum: RAM, TIMER, UNMAPPED.
REQ-034 The timer SHALL be the sub-module dmem_timer: register file, counter and PEND logic, with nIRQ as an output.
REQ-035 The top SHALL hold the address decode, the RAM array and the read mux.

Verification
REQ-036 Write 32'hDEADBEEF to 0x10 with be=1111, then to 0x10 with be=0010 and data 32'h0000AA00 -> a read of 0x10 returns 32'hDEADAAEF.
REQ-037 Read 0x10 with memread=0 -> readdata=0. Read 0x2000 (unmapped) -> readdata=0 and BUSERR stays 0.
REQ-038 TLOAD=3, then TCTRL=111 -> PEND sets 4 cycles after the TCTRL write, nIRQ=0 the next cycle, and the period is 4 with AUTO. W1C of TSTAT=1 -> nIRQ=1.
REQ-039 TCTRL=011, TLOAD=0 -> expiry on the first enabled cycle, then EN reads 0 and TCOUNT stays 0.
REQ-040 W1C of PEND in the exact expiry cycle -> PEND remains 1.
REQ-041 Write to 0x8000_0000 -> BUSERR=1 and RAM unchanged. Assert reset mid-countdown -> all registers read 0 and nIRQ=1 next cycle, while the RAM word at 0x10 is retained.
